// File: rtl/hlsm_pkg.sv
// Shared definitions for HLSM Start/Done job drivers: widths, FSM encoding,
// operand bundle layout and the post-timeout reset length.
package hlsm_pkg;

  localparam int OP_W             = 16;
  localparam int Z_W              = 8;
  localparam int HLSM_TMO_RST_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RECOVER   = 3'd3,
    S_DELIVER   = 3'd4
  } state_t;

  // One operand triple as stored in the FIFO (a in the top bits).
  typedef struct packed {
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
    logic signed [OP_W-1:0] c;
  } op_t;

endpackage

// File: rtl/hlsm_job_driver_if.sv
// Bundle of the upstream operand stream, the HLSM Start/Done port pair,
// the downstream result stream and the job statistics.
interface hlsm_job_driver_if
  import hlsm_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic signed [OP_W-1:0] in_a;
  logic signed [OP_W-1:0] in_b;
  logic signed [OP_W-1:0] in_c;

  logic                   start;
  logic signed [OP_W-1:0] a;
  logic signed [OP_W-1:0] b;
  logic signed [OP_W-1:0] c;
  logic                   done;
  logic signed [Z_W-1:0]  z;
  logic                   hlsm_rst;

  logic                   out_valid;
  logic                   out_ready;
  logic signed [Z_W-1:0]  out_z;
  logic                   out_tmo;

  logic [CNT_W-1:0]       jobs_cnt;
  logic [CNT_W-1:0]       tmo_cnt;

  modport master (
    input  in_valid, in_a, in_b, in_c, done, z, out_ready,
    output in_ready, start, a, b, c, hlsm_rst, out_valid, out_z, out_tmo,
           jobs_cnt, tmo_cnt
  );

  modport slave (
    output in_valid, in_a, in_b, in_c, done, z, out_ready,
    input  in_ready, start, a, b, c, hlsm_rst, out_valid, out_z, out_tmo,
           jobs_cnt, tmo_cnt
  );

endinterface

// File: rtl/hlsm_op_fifo.sv
// Small synchronous FIFO for operand triples. The head is read combinationally
// so the driver can pop it straight into its operand registers.
module hlsm_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // carries the extra state that tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign rdata = mem[rd_ptr_reg];

endmodule

// File: rtl/hlsm_job_driver.sv
// Initiator for HLSM Start/Done jobs: buffers operand triples, runs one job at
// a time with a Done timeout, resets the HLSM after an abort and streams z out.
module hlsm_job_driver
  import hlsm_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hlsm_job_driver_if.master bus
);

  state_t                state_reg;
  state_t                state_next;
  logic [CNT_W-1:0]      timer_reg;
  logic [CNT_W-1:0]      timer_next;
  logic                  ready_reg;
  op_t                   ops_reg;
  logic signed [Z_W-1:0] out_z_reg;
  logic                  out_tmo_reg;
  logic [CNT_W-1:0]      jobs_cnt_reg;
  logic [CNT_W-1:0]      tmo_cnt_reg;

  op_t                   in_ops;
  op_t                   head_ops;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  done_ok;
  logic                  tmo_hit;
  logic                  rcv_last;
  logic                  take_done;
  logic                  take_tmo;
  logic                  deliver_ack;

  assign in_ops.a  = bus.in_a;
  assign in_ops.b  = bus.in_b;
  assign in_ops.c  = bus.in_c;
  assign fifo_push = bus.in_valid & bus.in_ready;

  hlsm_op_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(op_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (in_ops),
    .pop   (fifo_pop),
    .rdata (head_ops),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A timer of zero marks the first WAIT_DONE cycle, where a Done still held
  // over from the previous job must not be mistaken for completion.
  assign done_ok  = bus.done && (timer_reg != '0);
  assign tmo_hit  = (timer_reg == CNT_W'(TIMEOUT - 1));
  assign rcv_last = (timer_reg == CNT_W'(HLSM_TMO_RST_CYC - 1));

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    fifo_pop    = 1'b0;
    take_done   = 1'b0;
    take_tmo    = 1'b0;
    deliver_ack = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_next = '0;
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_ok) begin
          take_done  = 1'b1;
          state_next = S_DELIVER;
        end else if (tmo_hit) begin
          take_tmo   = 1'b1;
          timer_next = '0;
          state_next = S_RECOVER;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (rcv_last) begin
          state_next = S_DELIVER;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end
      S_DELIVER: begin
        if (bus.out_ready) begin
          deliver_ack = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      ready_reg    <= 1'b0;
      ops_reg      <= '0;
      out_z_reg    <= '0;
      out_tmo_reg  <= 1'b0;
      jobs_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      ready_reg <= 1'b1;
      if (fifo_pop) begin
        ops_reg <= head_ops;
      end
      if (take_done) begin
        out_z_reg   <= bus.z;
        out_tmo_reg <= 1'b0;
      end else if (take_tmo) begin
        out_z_reg   <= '0;
        out_tmo_reg <= 1'b1;
        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
      end
      if (deliver_ack) begin
        jobs_cnt_reg <= jobs_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Start and HlsmRst decode straight from the state so reset drops them at once.
  assign bus.in_ready  = ready_reg & ~fifo_full;
  assign bus.start     = (state_reg == S_LAUNCH);
  assign bus.hlsm_rst  = (state_reg == S_RECOVER);
  assign bus.out_valid = (state_reg == S_DELIVER);
  assign bus.a         = ops_reg.a;
  assign bus.b         = ops_reg.b;
  assign bus.c         = ops_reg.c;
  assign bus.out_z     = out_z_reg;
  assign bus.out_tmo   = out_tmo_reg;
  assign bus.jobs_cnt  = jobs_cnt_reg;
  assign bus.tmo_cnt   = tmo_cnt_reg;

endmodule

// File: tb/tb_hlsm_job_driver.sv
// Directed bench for hlsm_job_driver with a behavioural HLSM responder
// (z = low byte of a+b+c, Done held two cycles).
module tb_hlsm_job_driver;

  localparam int CNT_W = 16;
  localparam int LIMIT = 500;

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [15:0] c;
    logic signed [7:0]  z;
    logic               tmo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hlsm_job_driver_if #(.CNT_W(CNT_W)) bus ();

  hlsm_job_driver #(
    .DEPTH   (4),
    .TIMEOUT (64),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_jobs = 0;
  int start_cnt = 0;
  int hrst_cnt = 0;
  int resp_mode = 0;   // 0 silent, 1 normal, 2 stale Done first
  int resp_n = 3;
  logic [47:0] resp_abc;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.start === 1'b1) start_cnt++;
    if (bus.hlsm_rst === 1'b1) hrst_cnt++;
  end

  // HLSM responder
  initial begin
    bus.done = 1'b0;
    bus.z    = '0;
    forever begin
      @(negedge clk);
      if (resp_mode != 0 && bus.start === 1'b1) begin
        resp_abc = {bus.a, bus.b, bus.c};
        if (resp_mode == 2) begin
          bus.done = 1'b1;
          bus.z    = 8'sd99;
          repeat (2) @(negedge clk);
          bus.done = 1'b0;
          bus.z    = '0;
          repeat (2) @(negedge clk);
          bus.z    = -8'sd7;
        end else begin
          repeat (resp_n) @(negedge clk);
          bus.z = 8'(bus.a + bus.b + bus.c);
        end
        check("abc_stable", {bus.a, bus.b, bus.c}, resp_abc);
        bus.done = 1'b1;
        repeat (2) @(negedge clk);
        bus.done = 1'b0;
      end
    end
  end

  task automatic push(input logic signed [15:0] pa, input logic signed [15:0] pb,
                      input logic signed [15:0] pc, output int waited);
    waited = 0;
    bus.in_a = pa;
    bus.in_b = pb;
    bus.in_c = pc;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check("push_accept", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_valid"}, bus.out_valid, 1'b1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (bus.start !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start"}, bus.start, 1'b1);
  endtask

  task automatic collect(input string name, input logic signed [7:0] ez,
                         input logic et, output int cycles);
    wait_valid(name, cycles);
    check({name, "_z"}, bus.out_z, ez);
    check({name, "_tmo"}, bus.out_tmo, et);
    $display("result %s z=%0d tmo=%0d cycles=%0d", name, bus.out_z, bus.out_tmo, cycles);
    @(negedge clk);
    exp_jobs++;
    check({name, "_jobs"}, bus.jobs_cnt, exp_jobs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, cyc, w5, cyc2, s0, h0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{a: 16'sd10,    b: 16'sd20,  c: 16'sd30, z: 8'sd60,   tmo: 1'b0};
    vecs[1] = '{a: -16'sd1,    b: -16'sd2,  c: -16'sd3, z: -8'sd6,   tmo: 1'b0};
    vecs[2] = '{a: 16'sd100,   b: 16'sd27,  c: 16'sd0,  z: 8'sd127,  tmo: 1'b0};
    vecs[3] = '{a: 16'sh7FFF,  b: 16'sd1,   c: 16'sd0,  z: 8'sd0,    tmo: 1'b0};
    vecs[4] = '{a: 16'sd200,   b: 16'sd55,  c: 16'sd0,  z: -8'sd1,   tmo: 1'b0};
    vecs[5] = '{a: -16'sd128,  b: 16'sd0,   c: 16'sd0,  z: -8'sd128, tmo: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_start", bus.start, 1'b0);
    check("rst_hlsm_rst", bus.hlsm_rst, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out", {bus.out_z, bus.out_tmo}, 9'd0);
    check("rst_cnts", {bus.jobs_cnt, bus.tmo_cnt}, 32'd0);
    check("rst_abc", {bus.a, bus.b, bus.c}, 48'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1'b1);

    // 1: single job, Start one cycle after the pop
    resp_mode = 1;
    resp_n = 3;
    bus.out_ready = 1'b1;
    s0 = start_cnt;
    push(16'sd3, 16'sd4, 16'sd5, w);
    @(negedge clk);
    check("t1_start_timing", bus.start, 1'b1);
    collect("t1", 8'sd12, 1'b0, cyc);
    check("t1_latency", cyc, 4);
    check("t1_one_start", start_cnt - s0, 1);

    // 2: burst fills the FIFO while the first result is back-pressured
    bus.out_ready = 1'b0;
    push(vecs[0].a, vecs[0].b, vecs[0].c, w);
    wait_valid("t2_first", cyc);
    for (int i = 1; i < 5; i++) push(vecs[i].a, vecs[i].b, vecs[i].c, w);
    check("t2_full_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    fork
      begin
        push(vecs[5].a, vecs[5].b, vecs[5].c, w5);
        check("t2_5th_after_pop", w5, 2);
      end
      begin
        for (int i = 0; i < 6; i++)
          collect($sformatf("t2_r%0d", i), vecs[i].z, vecs[i].tmo, cyc2);
      end
    join

    // 3: timeout, HLSM reset pulse, aborted result
    resp_mode = 0;
    h0 = hrst_cnt;
    push(16'sd7, 16'sd8, 16'sd9, w);
    wait_start("t3");
    collect("t3", 8'sd0, 1'b1, cyc);
    check("t3_latency", cyc, 67);
    check("t3_hlsm_rst_len", hrst_cnt - h0, 2);
    check("t3_tmo_cnt", bus.tmo_cnt, 1);

    // 4: stale Done in the first WAIT_DONE cycle is ignored
    resp_mode = 2;
    push(16'sd1, 16'sd1, 16'sd1, w);
    collect("t4", -8'sd7, 1'b0, cyc);

    // 5: backpressure holds the result and blocks the next launch
    resp_mode = 1;
    bus.out_ready = 1'b0;
    push(16'sd50, -16'sd20, 16'sd4, w);
    wait_valid("t5", cyc);
    push(16'sd1, 16'sd2, 16'sd3, w);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t5_hold_%0d", i), {bus.out_valid, bus.out_tmo, bus.out_z},
            {1'b1, 1'b0, 8'sd34});
      @(negedge clk);
    end
    check("t5_no_start", start_cnt - s0, 0);
    bus.out_ready = 1'b1;
    collect("t5_held", 8'sd34, 1'b0, cyc);
    collect("t5_next", 8'sd6, 1'b0, cyc);

    // 6: reset in WAIT_DONE
    resp_mode = 0;
    push(16'sd9, 16'sd9, 16'sd9, w);
    wait_start("t6");
    @(negedge clk);
    push(16'sd2, 16'sd2, 16'sd2, w);
    #2 rst_n = 1'b0;
    #1;
    check("t6_start", bus.start, 1'b0);
    check("t6_hlsm_rst", bus.hlsm_rst, 1'b0);
    check("t6_out_valid", bus.out_valid, 1'b0);
    check("t6_jobs_cnt", bus.jobs_cnt, 0);
    check("t6_tmo_cnt", bus.tmo_cnt, 0);
    check("t6_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_jobs = 0;
    s0 = start_cnt;
    repeat (5) @(negedge clk);
    check("t6_fifo_flushed", start_cnt - s0, 0);
    check("t6_rel_in_ready", bus.in_ready, 1'b1);
    resp_mode = 1;
    push(-16'sd3, -16'sd4, -16'sd5, w);
    collect("t6_fresh", -8'sd12, 1'b0, cyc);
    check("t6_tmo_cnt_after", bus.tmo_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
